// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// one-cycle valid / framing_err strobes and a held parallel data byte.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic             rx_meta_reg;
    logic             rx_s_reg;
    logic [2:0]       state_reg,       state_next;
    logic [CNT_W-1:0] clk_cnt_reg,     clk_cnt_next;
    logic [2:0]       bit_idx_reg,     bit_idx_next;
    logic [7:0]       shift_reg,       shift_next;
    logic [7:0]       data_reg,        data_next;
    logic             valid_reg,       valid_next;
    logic             framing_err_reg, framing_err_next;
    logic             capture;

    // Synchronizer flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Each data bit only loads when the FSM samples its own bit slot.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (capture && (bit_idx_reg == 3'(gi))) ?
                                    rx_s_reg : shift_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        clk_cnt_next     = clk_cnt_reg;
        bit_idx_next     = bit_idx_reg;
        data_next        = data_reg;
        valid_next       = 1'b0;
        framing_err_next = 1'b0;
        capture          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                end
            end

            START: begin
                if (clk_cnt_reg == HALF_END) begin
                    clk_cnt_next = '0;
                    if (!rx_s_reg) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt_reg == BIT_END) begin
                    capture      = 1'b1;
                    clk_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end

            STOP: begin
                if (clk_cnt_reg == BIT_END) begin
                    clk_cnt_next = '0;
                    if (rx_s_reg) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        framing_err_next = 1'b1;
                        state_next       = WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end
            end

            // A held-low line (break) must go idle before the next frame.
            WAIT_HIGH: begin
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next   = IDLE;
                clk_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            clk_cnt_reg     <= '0;
            bit_idx_reg     <= 3'd0;
            shift_reg       <= 8'h00;
            data_reg        <= 8'h00;
            valid_reg       <= 1'b0;
            framing_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            clk_cnt_reg     <= clk_cnt_next;
            bit_idx_reg     <= bit_idx_next;
            shift_reg       <= shift_next;
            data_reg        <= data_next;
            valid_reg       <= valid_next;
            framing_err_reg <= framing_err_next;
        end
    end

    assign data        = data_reg;
    assign valid       = valid_reg;
    assign framing_err = framing_err_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: table of frames plus hand-written
// glitch, break, reset-abort sequences; strobes are checked against a queue.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;
    // Pin edge to strobe: 2 sync + 1 idle detect + half bit + 9 full bits.
    localparam int LAT   = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 1 = valid, 2 = framing_err
        logic [7:0] data;
        int         due;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        bit         shifted;
        int         gap;
        int         exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[8];
    int         compared   = 0;
    int         mismatched = 0;
    int         ncyc       = 0;
    int         nstrobe    = 0;
    logic [7:0] last_good;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", name, act, expv);
        end
    endtask

    // One clock: wait for the falling edge, then check strobes against the queue.
    task automatic tick();
        exp_t e;
        int   got_kind;
        @(negedge clk);
        ncyc++;
        if (valid || framing_err) begin
            got_kind = (valid && !framing_err) ? 1 : ((!valid && framing_err) ? 2 : 3);
            compared++;
            nstrobe++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL strobe%0d unexpected: kind=%0d data=%02h cyc=%0d", nstrobe, got_kind, data, ncyc);
            end else begin
                e = sb.pop_front();
                if (got_kind != e.kind || data !== e.data || ncyc != e.due ||
                    busy !== (e.kind == 2)) begin
                    mismatched++;
                    $display("FAIL strobe%0d: got kind=%0d data=%02h cyc=%0d busy=%b, want kind=%0d data=%02h cyc=%0d busy=%b",
                             nstrobe, got_kind, data, ncyc, busy, e.kind, e.data, e.due, (e.kind == 2));
                end else begin
                    $display("strobe%0d kind=%0d data=%02h cyc=%0d ok", nstrobe, got_kind, data, ncyc);
                end
            end
        end else if (sb.size() > 0 && ncyc > sb[0].due) begin
            e = sb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missing strobe: none at cyc=%0d, want kind=%0d data=%02h", e.due, e.kind, e.data);
        end
    endtask

    // Drives ncycles of an 8N1 waveform; optional +/-3 clk jitter on bit edges.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit shifted,
                              input int ncycles, input int exp_kind, input logic [7:0] exp_data);
        exp_t e;
        int   idx;
        int   edge_t;
        for (int t = 0; t < ncycles; t++) begin
            tick();
            if (t == 0 && exp_kind != 0) begin
                e.kind = exp_kind;
                e.data = exp_data;
                e.due  = ncyc + LAT;
                sb.push_back(e);
            end
            idx = 0;
            for (int i = 1; i <= 9; i++) begin
                edge_t = i * CPB + (shifted ? ((i % 2 == 1) ? 3 : -3) : 0);
                if (t >= edge_t) idx = i;
            end
            if (idx == 0)      rx = 1'b0;
            else if (idx == 9) rx = stop;
            else               rx = d[idx-1];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            rx = 1'b1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 400) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain timeout: %0d strobes outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int busy_cnt;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 0,  1, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 0,  1, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 0,  1, 8'hFF};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 0,  1, 8'h81};
        vecs[4] = '{8'hC3, 1'b0, 1'b0, 48, 2, 8'h81};
        vecs[5] = '{8'h55, 1'b1, 1'b0, 0,  1, 8'h55};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 0,  1, 8'h01};
        vecs[7] = '{8'h80, 1'b1, 1'b0, 32, 1, 8'h80};

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        chk("reset data", 32'(data), 32'h00);
        chk("reset valid", 32'(valid), 32'h0);
        chk("reset framing_err", 32'(framing_err), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        reset     = 1'b0;
        last_good = 8'h00;
        idle(5);

        // Table: good frames back to back, jittered edges, one bad stop bit.
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].d, vecs[v].stop, vecs[v].shifted, FRAME,
                       vecs[v].exp_kind, vecs[v].exp_data);
            if (vecs[v].exp_kind == 1) last_good = vecs[v].d;
            idle(vecs[v].gap);
        end
        drain();
        idle(4);
        chk("busy after table", 32'(busy), 32'h0);
        chk("data after table", 32'(data), 32'(last_good));

        // Glitch: 4 clk low pulse is rejected at the start-bit re-sample.
        tick();
        rx = 1'b0;
        repeat (3) tick();
        tick();
        rx = 1'b1;
        busy_cnt = 0;
        repeat (30) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("glitch busy seen", 32'(busy_cnt >= 1 && busy_cnt <= 10), 32'h1);
        chk("glitch busy end", 32'(busy), 32'h0);

        // Break: bad stop bit then line held low for 5 bit times.
        send_frame(8'h3C, 1'b0, 1'b0, FRAME, 2, last_good);
        repeat (5 * CPB) begin
            tick();
            rx = 1'b0;
        end
        chk("break busy held", 32'(busy), 32'h1);
        chk("break data kept", 32'(data), 32'(last_good));
        idle(4);
        chk("break busy released", 32'(busy), 32'h0);
        idle(CPB);

        // Reset during data bit 4 aborts silently and clears data.
        send_frame(8'hC7, 1'b1, 1'b0, 5 * CPB, 0, 8'h00);
        tick();
        reset = 1'b1;
        rx    = 1'b1;
        tick();
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort data", 32'(data), 32'h00);
        chk("abort valid", 32'(valid), 32'h0);
        chk("abort framing_err", 32'(framing_err), 32'h0);
        reset     = 1'b0;
        last_good = 8'h00;
        idle(20);
        send_frame(8'h5A, 1'b1, 1'b0, FRAME, 1, 8'h5A);
        last_good = 8'h5A;
        drain();
        idle(4);
        chk("post-reset data", 32'(data), 32'(last_good));
        chk("post-reset busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
